text_vram_fetch: RTL

- Producer side of the text-mode draw path: turns the VGA controller's pixel coordinates into VRAM reads.
- Emits the 16-bit draw_code per pixel, with pixel coordinates and syncs delayed to match, for the color mapper to consume.
- Sits between the VGA timing generator, the VRAM read port (synchronous BRAM) and the color mapper.
- Screen is 640x480 with 8x16 glyphs: 80x30 characters, two draw codes packed per 32-bit VRAM word.

---
 rtl/text_vram_fetch_if.sv | 28 ++
 rtl/text_vram_fetch.sv | 119 +++++++++++
 2 files changed

// File: rtl/text_vram_fetch_if.sv
// Signal bundle between the VGA timing generator, the VRAM read port and the color mapper.
// The master modport is the fetch block; the slave modport is its environment.
interface text_vram_fetch_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        vde;
  logic        hsync;
  logic        vsync;
  logic [10:0] vram_addr;
  logic        vram_rd_en;
  logic [31:0] vram_rdata;
  logic [15:0] draw_code;
  logic [9:0]  DrawX_d;
  logic [9:0]  DrawY_d;
  logic        vde_d;
  logic        hsync_d;
  logic        vsync_d;

  modport master (
    input  DrawX, DrawY, vde, hsync, vsync, vram_rdata,
    output vram_addr, vram_rd_en, draw_code, DrawX_d, DrawY_d, vde_d, hsync_d, vsync_d
  );

  modport slave (
    output DrawX, DrawY, vde, hsync, vsync, vram_rdata,
    input  vram_addr, vram_rd_en, draw_code, DrawX_d, DrawY_d, vde_d, hsync_d, vsync_d
  );
endinterface

// File: rtl/text_vram_fetch.sv
// Text-mode VRAM fetch: pixel coordinates -> VRAM word reads -> 16-bit draw_code, timing delayed RD_LAT+1.
// Optional blinking cursor inversion is enabled with the TEXT_CURSOR_EN macro.
module text_vram_fetch #(
  parameter int RD_LAT = 2,
  parameter int COLS   = 80,
  parameter int ROWS   = 30
) (
  input  logic             Clk,
  input  logic             Reset,
`ifdef TEXT_CURSOR_EN
  input  logic [6:0]       cursor_col,
  input  logic [4:0]       cursor_row,
  input  logic [0:0]       cursor_on,
`endif
  text_vram_fetch_if.master bus
);

  localparam int         STAGES = RD_LAT + 1;
  localparam int         LS     = STAGES - 1;
  localparam logic [9:0] H_ACT  = 10'(COLS * 8);
  localparam logic [9:0] V_ACT  = 10'(ROWS * 16);

  logic [6:0]  w_col;
  logic [5:0]  w_row;
  logic [11:0] w_idx;
  logic        w_inrange;

  // idx = row*80 + col, built from shifts
  always_comb begin
    w_col     = bus.DrawX[9:3];
    w_row     = bus.DrawY[9:4];
    w_idx     = ({6'd0, w_row} << 6) + ({6'd0, w_row} << 4) + {5'd0, w_col};
    w_inrange = bus.vde && (bus.DrawX < H_ACT) && (bus.DrawY < V_ACT);
  end

  logic [10:0]       r_addr_p0;
  logic [9:0]        r_x_p [STAGES];
  logic [9:0]        r_y_p [STAGES];
  logic [STAGES-1:0] r_vde_p;
  logic [STAGES-1:0] r_hs_p;
  logic [STAGES-1:0] r_vs_p;
  logic [STAGES-1:0] r_half_p;
  logic [STAGES-1:0] r_inr_p;

  // Stage 0: address issue; stages 1..LS: delay line matching the BRAM latency
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_addr_p0 <= '0;
      r_vde_p   <= '0;
      r_hs_p    <= '0;
      r_vs_p    <= '0;
      r_half_p  <= '0;
      r_inr_p   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_x_p[i] <= '0;
        r_y_p[i] <= '0;
      end
    end else begin
      if (w_inrange)
        r_addr_p0 <= w_idx[11:1];
      r_x_p[0] <= bus.DrawX;
      r_y_p[0] <= bus.DrawY;
      for (int i = 1; i < STAGES; i++) begin
        r_x_p[i] <= r_x_p[i-1];
        r_y_p[i] <= r_y_p[i-1];
      end
      r_vde_p  <= {r_vde_p[STAGES-2:0],  bus.vde};
      r_hs_p   <= {r_hs_p[STAGES-2:0],   bus.hsync};
      r_vs_p   <= {r_vs_p[STAGES-2:0],   bus.vsync};
      r_half_p <= {r_half_p[STAGES-2:0], w_idx[0]};
      r_inr_p  <= {r_inr_p[STAGES-2:0],  w_inrange};
    end
  end

  // Output stage: half-word select, gated so flushed or out-of-range reads give blank
  logic [15:0] w_code_raw;
  always_comb begin
    w_code_raw = 16'h0000;
    if (r_inr_p[LS])
      w_code_raw = r_half_p[LS] ? bus.vram_rdata[31:16] : bus.vram_rdata[15:0];
  end

`ifdef TEXT_CURSOR_EN
  logic       r_vs_q;
  logic [5:0] r_frame_cnt;
  logic       w_cur_hit;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_vs_q      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_vs_q <= bus.vsync;
      if (r_vs_q && !bus.vsync)
        r_frame_cnt <= r_frame_cnt + 6'd1;
    end
  end

  // Blink phase is the counter MSB: 32 frames on, 32 frames off
  always_comb begin
    w_cur_hit = cursor_on[0] && r_frame_cnt[5] &&
                (r_x_p[LS][9:3] == cursor_col) &&
                (r_y_p[LS][9:4] == {1'b0, cursor_row});
  end

  assign bus.draw_code = {w_code_raw[15] ^ w_cur_hit, w_code_raw[14:0]};
`else
  assign bus.draw_code = w_code_raw;
`endif

  assign bus.vram_addr  = r_addr_p0;
  assign bus.vram_rd_en = r_inr_p[0];
  assign bus.DrawX_d    = r_x_p[LS];
  assign bus.DrawY_d    = r_y_p[LS];
  assign bus.vde_d      = r_vde_p[LS];
  assign bus.hsync_d    = r_hs_p[LS];
  assign bus.vsync_d    = r_vs_p[LS];

endmodule
